led_pulse_blinker: RTL and testbench

LED_PULSE_BLINKER -- requirements
Module: led_pulse_blinker

---
 rtl/led_pulse_blinker.sv | 112 +++++++++++
 tb/tb_led_pulse_blinker.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/led_pulse_blinker.sv
// Output-side counterpart of a button debouncer: stretches single-cycle event strobes into
// fixed-length, human-visible LED pulses, queueing up to 15 events behind the one on display.
module led_pulse_blinker #(
    parameter int unsigned ON_TICKS  = 20_000,
    parameter int unsigned OFF_TICKS = 20_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pulse_in,
    output logic       led_out,
    output logic       busy,
    output logic [3:0] pending,
    output logic       overflow
);

    localparam logic [14:0] OnLoad  = 15'(ON_TICKS - 1);
    localparam logic [14:0] OffLoad = 15'(OFF_TICKS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StOn,
        StGap
    } state_e;

    state_e      state_q, state_d;
    logic [14:0] timer_q, timer_d;
    logic [3:0]  pending_q, pending_d;
    logic        overflow_q, overflow_d;
    logic        led_q, led_d;
    logic        take;

    // Sequencing: take marks the cycle an event leaves the queue and starts its ON period.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        take    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pending_q != 4'd0) begin
                    state_d = StOn;
                    timer_d = OnLoad;
                    take    = 1'b1;
                end
            end
            StOn: begin
                if (timer_q == 15'd0) begin
                    state_d = StGap;
                    timer_d = OffLoad;
                end else begin
                    timer_d = timer_q - 15'd1;
                end
            end
            StGap: begin
                if (timer_q == 15'd0) begin
                    // Go straight back to ON so back-to-back events keep an exact period.
                    if (pending_q != 4'd0) begin
                        state_d = StOn;
                        timer_d = OnLoad;
                        take    = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    timer_d = timer_q - 15'd1;
                end
            end
            default: begin
                state_d = StIdle;
                timer_d = 15'd0;
            end
        endcase
    end

    // A strobe coinciding with a take simply replaces the event being taken.
    always_comb begin
        pending_d  = pending_q;
        overflow_d = overflow_q;
        if (pulse_in && !take) begin
            if (pending_q == 4'd15) begin
                overflow_d = 1'b1;
            end else begin
                pending_d = pending_q + 4'd1;
            end
        end else if (!pulse_in && take) begin
            pending_d = pending_q - 4'd1;
        end
    end

    assign led_d = (state_d == StOn);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            timer_q    <= 15'd0;
            pending_q  <= 4'd0;
            overflow_q <= 1'b0;
            led_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            led_q      <= led_d;
        end
    end

    assign led_out  = led_q;
    assign pending  = pending_q;
    assign overflow = overflow_q;
    assign busy     = (state_q != StIdle) || (pending_q != 4'd0);

endmodule

// File: tb/tb_led_pulse_blinker.sv
// Directed bench for led_pulse_blinker with ON_TICKS=4, OFF_TICKS=3; expected values are
// hand-derived cycle by cycle from the event-queue behaviour.
module tb_led_pulse_blinker;

    logic       clk;
    logic       rst_n;
    logic       pulse_in;
    logic       led_out;
    logic       busy;
    logic [3:0] pending;
    logic       overflow;

    int n_total;
    int n_bad;

    led_pulse_blinker #(
        .ON_TICKS (4),
        .OFF_TICKS(3)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .pulse_in(pulse_in),
        .led_out (led_out),
        .busy    (busy),
        .pending (pending),
        .overflow(overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One rising edge, then settle before sampling or driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        pulse_in = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int led_vec;
        int exp_vec;
        int peak;
        int rises;
        int prev_led;
        int cyc;
        int led_seen;
        int exp_led;

        n_total  = 0;
        n_bad    = 0;
        rst_n    = 1'b0;
        pulse_in = 1'b0;
        #3;
        check_val("reset_led", int'(led_out), 0);
        check_val("reset_busy", int'(busy), 0);
        check_val("reset_pending", int'(pending), 0);
        check_val("reset_overflow", int'(overflow), 0);
        step();
        step();

        // Single pulse, sampled on the very first edge after reset release.
        rst_n    = 1'b1;
        pulse_in = 1'b1;
        step();
        pulse_in = 1'b0;
        check_val("single_pending_k", int'(pending), 1);
        check_val("single_led_k", int'(led_out), 0);
        check_val("single_busy_k", int'(busy), 1);
        for (int i = 1; i <= 8; i++) begin
            step();
            exp_led = (i <= 4) ? 1 : 0;
            check_val($sformatf("single_led_k%0d", i), int'(led_out), exp_led);
            check_val($sformatf("single_busy_k%0d", i), int'(busy), (i <= 7) ? 1 : 0);
        end

        // Three back-to-back pulses: 4 on / 3 off three times, no idle cycle in between.
        do_reset();
        pulse_in = 1'b1;
        step();
        check_val("burst3_pending_k", int'(pending), 1);
        led_vec = 0;
        peak    = 0;
        for (int i = 0; i < 21; i++) begin
            step();
            if (i == 1) pulse_in = 1'b0;
            if (led_out) led_vec = led_vec | (1 << i);
            if (int'(pending) > peak) peak = int'(pending);
        end
        exp_vec = 0;
        for (int i = 0; i < 21; i++) begin
            if ((i % 7) < 4) exp_vec = exp_vec | (1 << i);
        end
        check_val("burst3_led_pattern", led_vec, exp_vec);
        check_val("burst3_pending_peak", peak, 2);
        step();
        check_val("burst3_busy_end", int'(busy), 0);

        // Pulse during ON (c=2) and on the exact GAP-exit edge (c=8).
        do_reset();
        pulse_in = 1'b1;
        step();
        check_val("mix_pending_0", int'(pending), 1);
        for (int c = 1; c <= 22; c++) begin
            pulse_in = (c == 2 || c == 8) ? 1'b1 : 1'b0;
            step();
            exp_led = ((c >= 1 && c <= 4) || (c >= 8 && c <= 11) || (c >= 15 && c <= 18))
                      ? 1 : 0;
            check_val($sformatf("mix_led_c%0d", c), int'(led_out), exp_led);
            if (c == 2) check_val("mix_pending_on", int'(pending), 1);
            if (c == 8) check_val("mix_pending_gapexit", int'(pending), 1);
            if (c == 15) check_val("mix_pending_last", int'(pending), 0);
        end
        pulse_in = 1'b0;
        check_val("mix_busy_end", int'(busy), 0);

        // Strobe held for 20 edges: queue saturates, two events dropped, 18 ON periods
        // (three start while the strobe is still high, then the 15 queued ones).
        do_reset();
        rises    = 0;
        prev_led = 0;
        for (int e = 1; e <= 20; e++) begin
            pulse_in = 1'b1;
            step();
            if (int'(led_out) == 1 && prev_led == 0) rises++;
            prev_led = int'(led_out);
            if (e == 18) begin
                check_val("sat_pending_e18", int'(pending), 15);
                check_val("sat_overflow_e18", int'(overflow), 0);
            end
            if (e == 19) check_val("sat_overflow_e19", int'(overflow), 1);
        end
        pulse_in = 1'b0;
        check_val("sat_pending_e20", int'(pending), 15);
        cyc = 0;
        while (busy && cyc < 400) begin
            step();
            cyc++;
            if (int'(led_out) == 1 && prev_led == 0) rises++;
            prev_led = int'(led_out);
        end
        check_val("sat_drain_in_time", (cyc < 400) ? 1 : 0, 1);
        check_val("sat_on_periods", rises, 18);
        check_val("sat_overflow_sticky", int'(overflow), 1);

        // Asynchronous reset mid-ON with three events queued.
        do_reset();
        for (int e = 1; e <= 4; e++) begin
            pulse_in = 1'b1;
            step();
        end
        pulse_in = 1'b0;
        check_val("rst_pre_led", int'(led_out), 1);
        check_val("rst_pre_pending", int'(pending), 3);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("rst_async_led", int'(led_out), 0);
        check_val("rst_async_busy", int'(busy), 0);
        check_val("rst_async_pending", int'(pending), 0);
        step();
        rst_n    = 1'b1;
        led_seen = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (led_out || busy) led_seen++;
        end
        check_val("rst_no_residual", led_seen, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
